ramb4_s2s8_fifo_ctrl: RTL and testbench

Single-clock controller that runs one X_RAMB4_S2_S8 block RAM as a 2048-symbol width-converting FIFO: 2-bit symbols are pushed through RAM port A and bytes are popped through RAM port B. It owns both pointers, occupancy, full/empty logic and the read-side valid/ready handshake. It sits between a 2-bit serial front end and a byte-wide consumer. The RAM itself is instantiated beside it in the parent wrapper `ramb4_s2s8_fifo`.

---
 rtl/ramb4_fifo_pkg.sv | 32 +++
 rtl/ramb4_s2s8_fifo_ctrl.sv | 110 +++++++++++
 tb/tb_ramb4_s2s8_fifo_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ramb4_fifo_pkg.sv
// Shared constants and controller state for the RAMB4 S2/S8 width-converting FIFO.
// Holds symbol/byte geometry, pointer widths, the registered controller state
// and the occupancy helper used by the controller.
package ramb4_fifo_pkg;

    localparam int unsigned SYM_W         = 2;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned DEPTH_SYM     = 2048;
    localparam int unsigned ADDRA_W       = 11;
    localparam int unsigned ADDRB_W       = 9;
    localparam int unsigned LEVEL_W       = 12;
    localparam int unsigned SYMS_PER_BYTE = BYTE_W / SYM_W;

    // Pointers carry one wrap bit above the RAM address.
    localparam int unsigned WP_W = ADDRA_W + 1;
    localparam int unsigned RP_W = ADDRB_W + 1;

    // Registered controller state.
    typedef struct packed {
        logic [WP_W-1:0] wp;
        logic [RP_W-1:0] rp;
        logic            m_valid;
        logic            ovf;
    } ctrl_state_t;

    // Stored symbols: write pointer minus read pointer scaled to symbols, mod 4096.
    function automatic logic [LEVEL_W-1:0] sym_level(input logic [WP_W-1:0] wp,
                                                     input logic [RP_W-1:0] rp);
        return LEVEL_W'(wp - {rp, 2'b00});
    endfunction

endpackage

// File: rtl/ramb4_s2s8_fifo_ctrl.sv
// Controller running one X_RAMB4_S2_S8 as a 2048-symbol FIFO: 2-bit symbols
// written on port A, bytes read on port B.
// Ports:
//   CLK, RST_N              clock, async active-low reset
//   FLUSH                   synchronous clear of pointers/valid/overflow
//   S_VALID/S_DATA/S_READY  2-bit push side
//   M_VALID/M_READY/M_DATA  byte pop side, M_DATA straight from RAM_DOB
//   FULL/EMPTY/AFULL/LEVEL  occupancy status from registered pointers
//   OVF                     sticky push-while-full flag
//   RAM_*                   RAM port A/B controls, RAM_DOB read data
module ramb4_s2s8_fifo_ctrl
    import ramb4_fifo_pkg::*;
#(
    parameter int unsigned AFULL_LVL = 1792
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 FLUSH,
    input  logic                 S_VALID,
    input  logic [SYM_W-1:0]     S_DATA,
    output logic                 S_READY,
    output logic                 M_VALID,
    input  logic                 M_READY,
    output logic [BYTE_W-1:0]    M_DATA,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic                 AFULL,
    output logic [LEVEL_W-1:0]   LEVEL,
    output logic                 OVF,
    output logic [ADDRA_W-1:0]   RAM_ADDRA,
    output logic [SYM_W-1:0]     RAM_DIA,
    output logic                 RAM_ENA,
    output logic                 RAM_WEA,
    output logic [ADDRB_W-1:0]   RAM_ADDRB,
    output logic                 RAM_ENB,
    input  logic [BYTE_W-1:0]    RAM_DOB,
    output logic                 RAM_RSTA,
    output logic                 RAM_RSTB,
    output logic                 RAM_WEB
);

    ctrl_state_t         st_q;
    ctrl_state_t         st_d;
    logic [LEVEL_W-1:0]  level;
    logic                full;
    logic                byte_avail;
    logic                push;
    logic                issue;

    // Occupancy and flags depend on registered pointers only.
    assign level      = sym_level(st_q.wp, st_q.rp);
    assign full       = (level == LEVEL_W'(DEPTH_SYM));
    assign byte_avail = (level >= LEVEL_W'(SYMS_PER_BYTE));

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    // Next state; FLUSH overrides push and pop, and no RAM access during reset.
    always_comb begin
        st_d  = st_q;
        push  = 1'b0;
        issue = 1'b0;
        if (FLUSH) begin
            st_d = '0;
        end else if (RST_N) begin
            push  = S_VALID && !full;
            issue = (!st_q.m_valid || M_READY) && byte_avail;
            if (push) begin
                st_d.wp = st_q.wp + WP_W'(1);
            end
            if (S_VALID && full) begin
                st_d.ovf = 1'b1;
            end
            if (issue) begin
                st_d.rp      = st_q.rp + RP_W'(1);
                st_d.m_valid = 1'b1;
            end else if (M_READY) begin
                st_d.m_valid = 1'b0;
            end
        end
    end

    assign S_READY   = !full;
    assign FULL      = full;
    assign EMPTY     = (level == '0);
    assign AFULL     = (level >= LEVEL_W'(AFULL_LVL));
    assign LEVEL     = level;
    assign OVF       = st_q.ovf;
    assign M_VALID   = st_q.m_valid;

    // RAM holds DOB while ENB is low, keeping M_DATA stable under back-pressure.
    assign M_DATA    = RAM_DOB;

    assign RAM_ENA   = push;
    assign RAM_WEA   = push;
    assign RAM_ADDRA = st_q.wp[ADDRA_W-1:0];
    assign RAM_DIA   = S_DATA;
    assign RAM_ENB   = issue;
    assign RAM_ADDRB = st_q.rp[ADDRB_W-1:0];
    assign RAM_RSTA  = 1'b0;
    assign RAM_RSTB  = 1'b0;
    assign RAM_WEB   = 1'b0;

endmodule

// File: tb/tb_ramb4_s2s8_fifo_ctrl.sv
// Bench for ramb4_s2s8_fifo_ctrl: behavioural RAM beside the DUT, a symbol-queue
// reference model, and directed plus randomized traffic.
module tb_ramb4_s2s8_fifo_ctrl;

    localparam int unsigned AFL   = 1792;
    localparam int unsigned DEPTH = 2048;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        FLUSH;
    logic        S_VALID;
    logic [1:0]  S_DATA;
    logic        S_READY;
    logic        M_VALID;
    logic        M_READY;
    logic [7:0]  M_DATA;
    logic        FULL, EMPTY, AFULL;
    logic [11:0] LEVEL;
    logic        OVF;
    logic [10:0] RAM_ADDRA;
    logic [1:0]  RAM_DIA;
    logic        RAM_ENA, RAM_WEA;
    logic [8:0]  RAM_ADDRB;
    logic        RAM_ENB;
    logic [7:0]  RAM_DOB;
    logic        RAM_RSTA, RAM_RSTB, RAM_WEB;

    always #5 CLK = ~CLK;

    ramb4_s2s8_fifo_ctrl #(.AFULL_LVL(AFL)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .S_VALID(S_VALID), .S_DATA(S_DATA), .S_READY(S_READY),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
        .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL), .LEVEL(LEVEL), .OVF(OVF),
        .RAM_ADDRA(RAM_ADDRA), .RAM_DIA(RAM_DIA), .RAM_ENA(RAM_ENA), .RAM_WEA(RAM_WEA),
        .RAM_ADDRB(RAM_ADDRB), .RAM_ENB(RAM_ENB), .RAM_DOB(RAM_DOB),
        .RAM_RSTA(RAM_RSTA), .RAM_RSTB(RAM_RSTB), .RAM_WEB(RAM_WEB)
    );

    // Behavioural S2/S8 RAM: byte n = symbols 4n..4n+3, symbol 4n in bits [1:0].
    logic [1:0] mem [0:2047];
    logic [7:0] dob;
    always @(posedge CLK) begin
        if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= RAM_DIA;
        if (RAM_ENB) dob <= {mem[{RAM_ADDRB, 2'd3}], mem[{RAM_ADDRB, 2'd2}],
                             mem[{RAM_ADDRB, 2'd1}], mem[{RAM_ADDRB, 2'd0}]};
    end
    assign RAM_DOB = dob;

    // Reference model state.
    logic [1:0]  q[$];
    bit          m_vld;
    logic [7:0]  m_byte;
    bit          m_ovf;
    int unsigned wr_cnt, rd_cnt;
    int          checks   = 0;
    int          failures = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        wr_cnt = 0;
        rd_cnt = 0;
    endtask

    task automatic check_state();
        chk("level",   32'(LEVEL),   32'(q.size()));
        chk("full",    32'(FULL),    32'(q.size() == DEPTH));
        chk("empty",   32'(EMPTY),   32'(q.size() == 0));
        chk("afull",   32'(AFULL),   32'(q.size() >= AFL));
        chk("s_ready", 32'(S_READY), 32'(q.size() != DEPTH));
        chk("m_valid", 32'(M_VALID), 32'(m_vld));
        chk("ovf",     32'(OVF),     32'(m_ovf));
        chk("const0",  32'({RAM_RSTA, RAM_RSTB, RAM_WEB}), 32'(0));
        if (m_vld) chk("m_data", 32'(M_DATA), 32'(m_byte));
    endtask

    // One clock: drive inputs just after negedge, check RAM strobes, advance model, check state.
    task automatic cycle(input bit sv, input logic [1:0] sd, input bit mr, input bit fl);
        bit         push_ok;
        bit         iss;
        logic [7:0] b;
        S_VALID = sv; S_DATA = sd; M_READY = mr; FLUSH = fl;
        push_ok = !fl && sv && (q.size() < DEPTH);
        iss     = !fl && (!m_vld || mr) && (q.size() >= 4);
        #1;
        chk("ram_ena", 32'(RAM_ENA), 32'(push_ok));
        chk("ram_wea", 32'(RAM_WEA), 32'(push_ok));
        chk("ram_enb", 32'(RAM_ENB), 32'(iss));
        if (push_ok) begin
            chk("ram_addra", 32'(RAM_ADDRA), wr_cnt % 2048);
            chk("ram_dia",   32'(RAM_DIA),   32'(sd));
        end
        if (iss) chk("ram_addrb", 32'(RAM_ADDRB), rd_cnt % 512);
        if (fl) begin
            model_reset();
        end else begin
            if (iss) begin
                b = {q[3], q[2], q[1], q[0]};
                repeat (4) void'(q.pop_front());
                m_byte = b;
                m_vld  = 1'b1;
                rd_cnt++;
            end else if (mr) begin
                m_vld = 1'b0;
            end
            if (sv) begin
                if (push_ok) begin
                    q.push_back(sd);
                    wr_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        check_state();
    endtask

    task automatic fill_to_full();
        for (int i = 0; i < 2200 && q.size() < DEPTH; i++) cycle(1'b1, 2'($urandom), 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (q.size() >= 4 || m_vld); i++) cycle(1'b0, 2'd0, 1'b1, 1'b0);
    endtask

    initial begin
        RST_N = 1'b0; FLUSH = 1'b0; S_VALID = 1'b0; S_DATA = 2'd0; M_READY = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        check_state();
        chk("rst_ena", 32'(RAM_ENA), 32'(0));
        chk("rst_enb", 32'(RAM_ENB), 32'(0));
        RST_N = 1'b1;

        // Directed 2,1,0,3 -> byte C6
        cycle(1'b1, 2'd2, 1'b1, 1'b0);
        cycle(1'b1, 2'd1, 1'b1, 1'b0);
        cycle(1'b1, 2'd0, 1'b1, 1'b0);
        cycle(1'b1, 2'd3, 1'b1, 1'b0);
        chk("c6_lvl4", 32'(LEVEL), 32'(4));
        chk("c6_notyet", 32'(M_VALID), 32'(0));
        cycle(1'b0, 2'd0, 1'b1, 1'b0);
        chk("c6_valid", 32'(M_VALID), 32'(1));
        chk("c6_data",  32'(M_DATA),  32'(8'hC6));
        chk("c6_lvl0",  32'(LEVEL),   32'(0));
        cycle(1'b0, 2'd0, 1'b1, 1'b0);

        // Fill to full with back-pressure, then overflow
        fill_to_full();
        chk("full_flag", 32'(FULL),    32'(1));
        chk("full_rdy",  32'(S_READY), 32'(0));
        chk("full_lvl",  32'(LEVEL),   32'(2048));
        chk("full_af",   32'(AFULL),   32'(1));
        cycle(1'b1, 2'd1, 1'b0, 1'b0);
        chk("ovf_set",   32'(OVF),     32'(1));
        chk("ovf_lvl",   32'(LEVEL),   32'(2048));
        drain();
        cycle(1'b0, 2'd0, 1'b0, 1'b1);
        chk("flush_ovf", 32'(OVF), 32'(0));

        // Three full-to-empty passes so both pointers wrap
        for (int p = 0; p < 3; p++) begin
            fill_to_full();
            drain();
            chk("wrap_empty", 32'(EMPTY), 32'(1));
        end
        cycle(1'b0, 2'd0, 1'b0, 1'b1);

        // Six symbols then stall: one byte out, two symbols left
        for (int i = 0; i < 6; i++) cycle(1'b1, 2'($urandom), 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 2'd0, 1'b0, 1'b0);
        chk("stall_lvl", 32'(LEVEL), 32'(2));
        chk("stall_vld", 32'(M_VALID), 32'(1));
        cycle(1'b0, 2'd0, 1'b1, 1'b0);
        chk("stall_done", 32'(M_VALID), 32'(0));
        chk("stall_lvl2", 32'(LEVEL), 32'(2));
        cycle(1'b0, 2'd0, 1'b0, 1'b1);

        // Random concurrent traffic: light then heavy back-pressure
        repeat (1500) cycle($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 1) == 1, 1'b0);
        repeat (2500) cycle($urandom_range(0, 7) != 0, 2'($urandom), $urandom_range(0, 15) == 0, 1'b0);
        drain();

        // FLUSH together with a push
        for (int i = 0; i < 7; i++) cycle(1'b1, 2'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 2'd1, 1'b1, 1'b1);
        chk("flush_lvl", 32'(LEVEL),   32'(0));
        chk("flush_vld", 32'(M_VALID), 32'(0));

        // Asynchronous reset mid-stream
        for (int i = 0; i < 9; i++) cycle(1'b1, 2'($urandom), 1'b0, 1'b0);
        chk("pre_rst_vld", 32'(M_VALID), 32'(1));
        S_VALID = 1'b1; M_READY = 1'b1;
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        check_state();
        chk("arst_ena", 32'(RAM_ENA), 32'(0));
        chk("arst_enb", 32'(RAM_ENB), 32'(0));
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) cycle(1'b1, 2'($urandom), 1'b1, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
